// File: rtl/nios2_jtag_debug_cmd_bridge.sv
// System-clock side of the Nios II JTAG debug path: synchronises the TCK-domain
// update strobes, buffers scanned commands in a small FIFO and issues them to
// the OCI debug logic as a registered data word plus one-hot action pulses.
module nios2_jtag_debug_cmd_bridge #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACTION_BIT  = 34
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             vs_udr,
    input  logic                             vs_uir,
    input  logic [IR_W-1:0]                  ir_in,
    input  logic [DATA_W-1:0]                sr,
    input  logic                             cmd_ready,
    input  logic                             overflow_clr,
    output logic                             cmd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic [DATA_W-1:0]                jdo,
    output logic [IR_W-1:0]                  jdo_ir,
    output logic [(2**IR_W)-1:0]             take_action,
    output logic [(2**IR_W)-1:0]             take_no_action,
    output logic [IR_W-1:0]                  ir_reg,
    output logic                             ir_update,
    output logic                             overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = IR_W + DATA_W;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   udr_d;
    logic                   uir_d;
    logic                   udr_armed;
    logic                   uir_armed;
    logic                   udr_s;
    logic                   uir_s;
    logic                   fill_done;
    logic                   udr_rise;
    logic                   uir_rise;

    logic [ENT_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [IR_W-1:0]        head_ir;
    logic [DATA_W-1:0]      head_data;

    assign udr_s     = udr_sync[SYNC_STAGES-1];
    assign uir_s     = uir_sync[SYNC_STAGES-1];
    assign fill_done = fill[SYNC_STAGES-1];
    assign udr_rise  = udr_s & ~udr_d & udr_armed;
    assign uir_rise  = uir_s & ~uir_d & uir_armed;

    // The chains reset to 0, so a low on s only means the strobe is genuinely
    // low once real samples have reached the last stage; fill tracks that, so a
    // strobe held high through reset release never arms and never fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync  <= '0;
            uir_sync  <= '0;
            fill      <= '0;
            udr_d     <= 1'b0;
            uir_d     <= 1'b0;
            udr_armed <= 1'b0;
            uir_armed <= 1'b0;
        end else begin
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            udr_d     <= udr_s;
            uir_d     <= uir_s;
            udr_armed <= udr_armed | (fill_done & ~udr_s);
            uir_armed <= uir_armed | (fill_done & ~uir_s);
        end
    end

    assign cmd_valid            = (fifo_count != '0);
    assign pop                  = cmd_valid & cmd_ready;
    assign push                 = udr_rise & ((fifo_count < CNT_W'(FIFO_DEPTH)) | pop);
    assign drop                 = udr_rise & ~push;
    assign {head_ir, head_data} = mem[rd_ptr];

    // Command storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= {ir_in, sr};
        end
    end

    // FIFO bookkeeping, command issue, IR capture and overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            jdo            <= '0;
            jdo_ir         <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            ir_reg         <= '0;
            ir_update      <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            ir_update      <= uir_rise;
            if (uir_rise) begin
                ir_reg <= ir_in;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                jdo    <= head_data;
                jdo_ir <= head_ir;
                if (head_data[ACTION_BIT]) begin
                    take_action[head_ir] <= 1'b1;
                end else begin
                    take_no_action[head_ir] <= 1'b1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_jtag_debug_cmd_bridge.sv
// Bench for nios2_jtag_debug_cmd_bridge: directed scenarios with literal
// expectations, then randomized strobes checked every cycle against a
// queue-based model of the command path.
module tb_nios2_jtag_debug_cmd_bridge;

    localparam int DATA_W = 38;
    localparam int IR_W   = 2;
    localparam int DEPTH  = 4;
    localparam int SS     = 2;
    localparam int ABIT   = 34;
    localparam int NUM_IR = 2 ** IR_W;
    localparam int ENT_W  = IR_W + DATA_W;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      vs_udr = 1'b0;
    logic                      vs_uir = 1'b0;
    logic [IR_W-1:0]           ir_in = '0;
    logic [DATA_W-1:0]         sr = '0;
    logic                      cmd_ready = 1'b0;
    logic                      overflow_clr = 1'b0;
    logic                      cmd_valid;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic [DATA_W-1:0]         jdo;
    logic [IR_W-1:0]           jdo_ir;
    logic [NUM_IR-1:0]         take_action;
    logic [NUM_IR-1:0]         take_no_action;
    logic [IR_W-1:0]           ir_reg;
    logic                      ir_update;
    logic                      overflow;

    nios2_jtag_debug_cmd_bridge #(
        .DATA_W(DATA_W), .IR_W(IR_W), .FIFO_DEPTH(DEPTH),
        .SYNC_STAGES(SS), .ACTION_BIT(ABIT)
    ) dut (
        .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
        .cmd_valid(cmd_valid), .fifo_count(fifo_count), .jdo(jdo), .jdo_ir(jdo_ir),
        .take_action(take_action), .take_no_action(take_no_action),
        .ir_reg(ir_reg), .ir_update(ir_update), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [ENT_W-1:0]  mq[$];
    logic [DATA_W-1:0] m_jdo;
    logic [IR_W-1:0]   m_jdo_ir;
    logic [IR_W-1:0]   m_ir;
    logic [NUM_IR-1:0] m_ta;
    logic [NUM_IR-1:0] m_tna;
    logic              m_iru;
    logic              m_ovf;
    bit                udr_h[$];
    bit                uir_h[$];
    int                n_since_rst;
    bit                model_live = 0;
    bit                m_ue, m_ie, m_pop, m_drop;
    logic [ENT_W-1:0]  m_head;

    // An event fires SS edges after the first high sample that follows a low
    // sample taken since reset release.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            mq.delete(); udr_h.delete(); uir_h.delete();
            n_since_rst = 0;
            m_jdo = '0; m_jdo_ir = '0; m_ir = '0; m_ta = '0; m_tna = '0;
            m_iru = 1'b0; m_ovf = 1'b0;
            model_live = 1;
        end else begin
            n_since_rst++;
            udr_h.push_front(vs_udr);
            uir_h.push_front(vs_uir);
            if (udr_h.size() > SS + 2) void'(udr_h.pop_back());
            if (uir_h.size() > SS + 2) void'(uir_h.pop_back());
            m_ue = (n_since_rst >= SS + 2) && udr_h[SS] && !udr_h[SS+1];
            m_ie = (n_since_rst >= SS + 2) && uir_h[SS] && !uir_h[SS+1];
            m_ta = '0;
            m_tna = '0;
            m_pop = (mq.size() != 0) && cmd_ready;
            if (m_pop) begin
                m_head = mq.pop_front();
                m_jdo = m_head[DATA_W-1:0];
                m_jdo_ir = m_head[ENT_W-1:DATA_W];
                if (m_jdo[ABIT]) m_ta[m_jdo_ir] = 1'b1;
                else             m_tna[m_jdo_ir] = 1'b1;
            end
            m_drop = 0;
            if (m_ue) begin
                if (mq.size() < DEPTH) mq.push_back({ir_in, sr});
                else m_drop = 1;
            end
            if (overflow_clr) m_ovf = 1'b0;
            if (m_drop) m_ovf = 1'b1;
            m_iru = m_ie;
            if (m_ie) m_ir = ir_in;
        end
    end

    // ---------------- per-cycle compare + pulse logs ----------------
    logic [NUM_IR-1:0] ta_log[$];
    logic [NUM_IR-1:0] tna_log[$];
    int                iru_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            chk("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
            chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
            chk("jdo", 64'(jdo), 64'(m_jdo));
            chk("jdo_ir", 64'(jdo_ir), 64'(m_jdo_ir));
            chk("take_action", 64'(take_action), 64'(m_ta));
            chk("take_no_action", 64'(take_no_action), 64'(m_tna));
            chk("ir_reg", 64'(ir_reg), 64'(m_ir));
            chk("ir_update", 64'(ir_update), 64'(m_iru));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (take_action != '0) ta_log.push_back(take_action);
            if (take_no_action != '0) tna_log.push_back(take_no_action);
            if (ir_update) iru_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rand_mode = 0;

    task automatic tick(input int n);
        repeat (n) begin
            if (rand_mode) begin
                cmd_ready = ($urandom_range(4) < 2);
                overflow_clr = ($urandom_range(15) == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic scan(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d,
                        input int hi, input int lo);
        ir_in = ir; sr = d; vs_udr = 1'b1;
        tick(hi);
        vs_udr = 1'b0;
        tick(lo);
    endtask

    task automatic iscan(input logic [IR_W-1:0] ir, input int hi, input int lo);
        ir_in = ir; vs_uir = 1'b1;
        tick(hi);
        vs_uir = 1'b0;
        tick(lo);
    endtask

    localparam logic [DATA_W-1:0] D_ACT = 38'h04_DEAD_BEEF;
    localparam logic [DATA_W-1:0] D_NEW = 38'h3F_0000_00AA;
    logic [NUM_IR-1:0] exp_tna [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] rd;
        int cnt0;
        @(negedge clk);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        tick(4);

        // single scan with exact timing
        cmd_ready = 1'b1;
        ir_in = 2'd2; sr = D_ACT; vs_udr = 1'b1;
        tick(SS);
        chk("t1_valid_early", 64'(cmd_valid), 64'd0);
        tick(1);
        chk("t1_valid_push", 64'(cmd_valid), 64'd1);
        tick(1);
        chk("t1_valid_popped", 64'(cmd_valid), 64'd0);
        chk("t1_jdo", 64'(jdo), 64'(D_ACT));
        chk("t1_jdo_ir", 64'(jdo_ir), 64'd2);
        chk("t1_take_action", 64'(take_action), 64'h4);
        chk("t1_take_no_action", 64'(take_no_action), 64'h0);
        tick(1);
        chk("t1_pulse_end", 64'(take_action), 64'h0);
        vs_udr = 1'b0;
        tick(SS + 2);

        // five scans into a four-deep FIFO
        cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) scan(2'(k % 4), 38'h00_1234_5670 + 38'(k), SS + 2, SS + 2);
        chk("t2_count", 64'(fifo_count), 64'd4);
        chk("t2_overflow", 64'(overflow), 64'd1);
        ta_log.delete(); tna_log.delete();
        cmd_ready = 1'b1;
        tick(6);
        cmd_ready = 1'b0;
        chk("t2_npulses", 64'(tna_log.size()), 64'd4);
        chk("t2_nactions", 64'(ta_log.size()), 64'd0);
        for (int i = 0; i < 4; i++) chk("t2_order", 64'(tna_log[i]), 64'(exp_tna[i]));
        chk("t2_last_jdo", 64'(jdo), 64'h00_1234_5673);

        // push accepted on a full FIFO when a pop coincides
        overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
        for (int k = 0; k < 4; k++) scan(2'(k), 38'h00_0000_1000 + 38'(k), SS + 2, SS + 2);
        ir_in = 2'd1; sr = D_NEW; vs_udr = 1'b1;
        tick(SS);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("t3_count", 64'(fifo_count), 64'd4);
        chk("t3_overflow", 64'(overflow), 64'd0);
        chk("t3_jdo_first", 64'(jdo), 64'h00_0000_1000);
        vs_udr = 1'b0;
        tick(SS + 2);
        ta_log.delete();
        cmd_ready = 1'b1;
        tick(6);
        cmd_ready = 1'b0;
        chk("t3_jdo_last", 64'(jdo), 64'(D_NEW));
        chk("t3_jdo_ir_last", 64'(jdo_ir), 64'd1);
        chk("t3_last_action", 64'(ta_log.size() > 0 ? ta_log[ta_log.size()-1] : 4'h0), 64'h2);
        chk("t3_drained", 64'(fifo_count), 64'd0);

        // update-IR
        iru_cnt = 0;
        cnt0 = int'(fifo_count);
        iscan(2'd3, SS + 2, SS + 2);
        chk("t4_ir_reg", 64'(ir_reg), 64'd3);
        chk("t4_ir_update_cnt", 64'(iru_cnt), 64'd1);
        chk("t4_count", 64'(fifo_count), 64'(cnt0));

        // strobe high across reset release
        vs_udr = 1'b1; reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(8);
        chk("t5_no_cmd", 64'(fifo_count), 64'd0);
        vs_udr = 1'b0; tick(SS + 2);
        vs_udr = 1'b1; tick(SS + 2);
        vs_udr = 1'b0; tick(SS + 2);
        chk("t5_one_cmd", 64'(fifo_count), 64'd1);

        // reset discards queued commands
        scan(2'd0, 38'h00_0000_0001, SS + 2, SS + 2);
        scan(2'd1, 38'h00_0000_0002, SS + 2, SS + 2);
        chk("t6_count3", 64'(fifo_count), 64'd3);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("t6_count", 64'(fifo_count), 64'd0);
        chk("t6_valid", 64'(cmd_valid), 64'd0);
        chk("t6_jdo", 64'(jdo), 64'd0);
        tick(4);

        // overflow set wins over clear
        for (int k = 0; k < 4; k++) scan(2'(k), 38'h00_0000_0100 + 38'(k), SS + 2, SS + 2);
        chk("t7_ovf_before", 64'(overflow), 64'd0);
        ir_in = 2'd0; sr = 38'h00_0000_0200; vs_udr = 1'b1;
        tick(SS);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("t7_ovf_set_wins", 64'(overflow), 64'd1);
        chk("t7_count", 64'(fifo_count), 64'd4);
        vs_udr = 1'b0; tick(SS + 2);
        overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
        chk("t7_ovf_cleared", 64'(overflow), 64'd0);

        // randomized phase, model-checked every cycle
        rand_mode = 1;
        for (int it = 0; it < 300; it++) begin
            int op;
            op = int'($urandom_range(9));
            rd = {6'($urandom), $urandom};
            if (it == 150) begin
                reset = 1'b1; tick(2); reset = 1'b0; tick(SS + 2);
            end else if (op <= 5) begin
                scan(2'($urandom), rd, SS + 1 + int'($urandom_range(3)), SS + 1 + int'($urandom_range(3)));
            end else if (op <= 7) begin
                iscan(2'($urandom), SS + 1 + int'($urandom_range(3)), SS + 1 + int'($urandom_range(3)));
            end else begin
                tick(1 + int'($urandom_range(3)));
            end
        end
        rand_mode = 0;
        cmd_ready = 1'b1;
        tick(8);
        chk("end_drained", 64'(fifo_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
